// File: rtl/score_display.sv
// Binary-to-BCD score display: sequential double-dabble conversion into a
// display register, decoded onto active-low 7-segment cathodes per scanned anode.
module score_display #(
  parameter int unsigned nSeg     = 8,
  parameter int unsigned VAL_W    = 16,
  parameter int unsigned NDIG     = 5,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VAL_W-1:0] value,
  input  logic             load,
  output logic             busy,
  output logic             done,
  input  logic [nSeg-1:0]  AN,
  output logic [6:0]       SEG,
  output logic             DP
);

  localparam int unsigned BCD_W = 4 * NDIG;
  localparam int unsigned CNT_W = $clog2(VAL_W + 1);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t             state_q, state_d;
  logic [VAL_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   disp_q, disp_d;
  logic               busy_d, done_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state and double-dabble step
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    case (state_q)
      IDLE: begin
        if (load) begin
          shift_d = value;
          bcd_d   = '0;
          cnt_d   = CNT_W'(VAL_W);
          state_d = CONV;
        end
      end
      CONV: begin
        {bcd_d, shift_d} = {bcd_adj[BCD_W-2:0], shift_q, 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = COMMIT;
      end
      COMMIT: begin
        disp_d  = bcd_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == COMMIT);
  end

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  logic [nSeg-1:0] an_low;
  logic            sel_ok;
  logic [NDIG-1:0] zero_above;

  // Digit select: only a single low anode inside the converted range lights
  always_comb begin
    an_low = ~AN;
    sel_ok = (an_low != '0) && ((an_low & (an_low - nSeg'(1))) == '0);
    SEG    = 7'b1111111;
    for (int unsigned i = 0; i < NDIG; i++) begin
      zero_above[i] = ((disp_q >> (4*i)) == '0);
    end
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (sel_ok && an_low[i]) begin
        if (BLANK_LZ && (i != 0) && zero_above[i]) SEG = 7'b1111111;
        else                                        SEG = glyph(disp_q[4*i +: 4]);
      end
    end
  end

  assign DP = 1'b1;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: directed scenarios plus random values
// checked against a decimal-arithmetic model of the displayed digits.
module tb_score_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic        busy;
  logic        done;
  logic [7:0]  AN;
  logic [6:0]  SEG;
  logic        DP;

  int checks = 0;
  int errors = 0;
  int unsigned shown = 0;

  localparam logic [6:0] GLYPH [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  score_display dut (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .busy(busy), .done(done), .AN(AN), .SEG(SEG), .DP(DP)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected cathodes from the decimal value being shown and the anode vector
  function automatic logic [6:0] exp_seg(input int unsigned val, input logic [7:0] an);
    logic [7:0]  low;
    int          idx;
    int unsigned p;
    low = ~an;
    idx = 0;
    p   = 1;
    if ($countones(low) != 1) return 7'h7f;
    for (int i = 0; i < 8; i++) if (low[i]) idx = i;
    if (idx >= 5) return 7'h7f;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (idx > 0 && val < p) return 7'h7f;
    return GLYPH[(val / p) % 10];
  endfunction

  task automatic check_display(input string tag);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      AN = ~(8'b1 << i);
      #1;
      check(tag, {25'd0, SEG}, {25'd0, exp_seg(shown, AN)});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      AN = 8'($urandom);
      #1;
      check({tag, "_rand_an"}, {25'd0, SEG}, {25'd0, exp_seg(shown, AN)});
    end
    check("dp", {31'd0, DP}, 32'd1);
  endtask

  task automatic convert(input logic [15:0] v);
    int bc;
    int dc;
    bc = 0;
    dc = 0;
    value = v;
    load  = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    while (busy && bc < 100) begin
      bc++;
      if (done) dc++;
      @(posedge clk); #1;
    end
    check("busy_len", bc, 17);
    check("done_cnt", dc, 1);
    check("done_after", {31'd0, done}, 32'd0);
    shown = v;
  endtask

  initial begin
    int bc;
    int dc;
    rst   = 1'b0;
    load  = 1'b0;
    value = '0;
    AN    = 8'b11111110;
    #1;
    check("rst_seg0", {25'd0, SEG}, {25'd0, 7'b1000000});
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    AN = 8'b11111101;
    #1;
    check("rst_seg1_blank", {25'd0, SEG}, {25'd0, 7'b1111111});
    #10;
    rst = 1'b1;
    check_display("idle_zero");

    convert(16'd1234);
    check_display("v1234");
    convert(16'd65535);
    check_display("v65535");
    convert(16'd0);
    check_display("v0");

    // Illegal AN patterns blank the display
    AN = 8'b10111111; #1; check("an_idx6", {25'd0, SEG}, {25'd0, 7'b1111111});
    AN = 8'b11111100; #1; check("an_two",  {25'd0, SEG}, {25'd0, 7'b1111111});
    AN = 8'hFF;       #1; check("an_none", {25'd0, SEG}, {25'd0, 7'b1111111});

    // Load during a conversion is dropped
    @(negedge clk);
    value = 16'd1234; load = 1'b1;
    @(posedge clk); #1; load = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    value = 16'd99; load = 1'b1;
    @(posedge clk); #1; load = 1'b0;
    bc = 0; dc = 0;
    while (busy && bc < 100) begin
      bc++;
      if (done) dc++;
      @(posedge clk); #1;
    end
    check("ign_done_cnt", dc, 1);
    check("ign_busy_rest", bc, 12);
    repeat (3) begin @(posedge clk); #1; end
    check("ign_busy_idle", {31'd0, busy}, 32'd0);
    shown = 1234;
    check_display("ignored_load");

    // Load held high: back-to-back conversions, 18-cycle period
    @(negedge clk);
    value = 16'd42; load = 1'b1;
    dc = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 36; k++) begin
      if (done) dc++;
      if (k == 34) load = 1'b0;
      @(posedge clk); #1;
    end
    check("held_done_cnt", dc, 2);
    check("held_busy_end", {31'd0, busy}, 32'd0);
    shown = 42;
    check_display("held");

    // Async reset mid-conversion
    @(negedge clk);
    value = 16'd500; load = 1'b1;
    @(posedge clk); #1; load = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    rst = 1'b0;
    AN  = 8'b11111110;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_seg0", {25'd0, SEG}, {25'd0, 7'b1000000});
    #2;
    rst = 1'b1;
    dc = 0;
    repeat (20) begin @(posedge clk); #1; if (done || busy) dc++; end
    check("abort_quiet", dc, 0);
    shown = 0;
    check_display("after_abort");
    convert(16'd7);
    AN = 8'b11111110; #1;
    check("seven", {25'd0, SEG}, {25'd0, 7'b1111000});
    check_display("v7");

    // Random values against the decimal model
    for (int k = 0; k < 8; k++) begin
      convert(16'($urandom_range(0, 65535)));
      check_display("rand");
    end
    convert(16'd10);
    check_display("v10");
    convert(16'd10000);
    check_display("v10000");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_display.md
Name: score_display

Overview:
- Consumer of the anode scan: takes the rotating active-low anode vector and a binary value from game logic, and drives the active-low 7-segment cathodes for whichever digit is currently enabled.
- Converts binary to BCD with a sequential shift-and-add-3 (double-dabble) engine.
- Holds the converted digits in a display register, so the display never shows a partial conversion.

Parameters:
- nSeg, 8: number of anode positions; width of AN.
- VAL_W, 16: width of the binary input value.
- NDIG, 5: number of BCD digits converted. Legal only if 10^NDIG > 2^VAL_W - 1 and 1 <= NDIG <= nSeg.
- BLANK_LZ, 1: 1 = blank leading zeros; digit 0 is never blanked.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- value  in  VAL_W  binary value to display.
- load  in  1  request conversion of value; sampled on a rising clk edge.
- busy  out  1  conversion in progress; load is ignored while high.
- done  out  1  one-cycle pulse in the cycle the display register updates.
- AN  in  8  anode vector from the scan driver; active-low one-hot; bit i = digit i (0 = rightmost).
- SEG  out  7  cathodes, active-low, bit order {g,f,e,d,c,b,a}.
- DP  out  1  decimal point, active-low; constant 1 (off).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, busy=0, done=0.
  - Shift register, BCD accumulator and bit counter cleared.
  - Display register = all zeros.
  - SEG/DP stay purely combinational from AN and the display register, so during and after reset digit 0 shows "0".
- FSM states: IDLE, CONV, COMMIT.
- IDLE:
  - load=1 at edge N: capture value into shift register, clear BCD accumulator, counter=VAL_W, go to CONV.
  - busy=1 from cycle N+1.
- CONV, one step per cycle:
  - Every BCD nibble >= 5 gets +3.
  - Then the {BCD, shift} concatenation shifts left by 1; MSB of shift enters BCD bit 0.
  - Counter decrements each step; after the VAL_W-th step go to COMMIT.
- COMMIT, one cycle:
  - Display register <= BCD accumulator; done=1; busy=0 next cycle; return to IDLE.
- Latency: load sampled at edge N -> done high in cycle N+VAL_W+1 -> new digits on SEG from cycle N+VAL_W+2.
- busy is high for exactly VAL_W+1 cycles.
- load while busy: ignored, with no queueing.
- load in the same cycle COMMIT asserts done: ignored, because busy is still high that cycle.
- load held high continuously: re-converts back-to-back. The FSM returns to IDLE for 1 cycle, then restarts.
- Display register changes only in COMMIT. The old value is shown for the whole conversion.
- Digit select (combinational):
  - Exactly one AN bit low at index i < NDIG: show digit i.
  - Low bit at index i >= NDIG, AN == all ones, or more than one bit low: SEG=7'b1111111 (blank).
- Leading-zero blanking (BLANK_LZ=1): digit i > 0 is blanked when it and every digit above it up to NDIG-1 are 0.
- Glyphs, {g..a} active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibble > 9 (cannot occur) shows blank.
- Async reset mid-CONV aborts the conversion immediately and clears the display register. No done pulse is generated.

Test Plan:
- Reset, AN=8'b11111110 -> SEG=1000000, busy=0. AN=8'b11111101 -> SEG=1111111 (leading zero blanked).
- load value=16'd1234 -> busy high 17 cycles, done pulses once. Then AN digit0..3 -> SEG 0110011? no: digit0=4:0011001, digit1=3:0110000, digit2=2:0100100, digit3=1:1111001. Digit4 blank.
- value=16'd65535 -> digits 5,3,5,5,6 (digit4=6:0000010). value=0 -> only digit0 "0" lit.
- Second load with value=99 issued 5 cycles into a conversion of 1234 -> ignored; display shows 1234 after done.
- AN=8'b10111111 (index 6 >= NDIG), AN=8'b11111100 (two lows), AN=8'hFF -> SEG=1111111 in each case.
- rst pulsed low mid-CONV of 500 -> busy=0 immediately, no done pulse, display shows "0". A subsequent load of 7 -> digit0=1111000.
